// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between NUM_REQ requesters
// (index 0 is the processor core, 1.. are host/loader engines). One access per
// grant, sequenced through IDLE -> ACCESS -> (RESP) -> IDLE, with read data
// routed back to the winning requester.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest requesting index wins
//                           undefined -> round-robin starting after the last winner
module dmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] last_r;   // last granted requester (round-robin pointer)
  logic [IDX_W-1:0] win_r;    // requester owning the access in flight
  logic [CNT_W-1:0] cnt_r;    // remaining read-latency cycles
  logic [IDX_W-1:0] win_s;
  logic             found_s;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Winner selection: lowest requesting index, so the core always preempts loaders.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_s) begin
        win_s   = IDX_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  int rr_idx_s;

  // Winner selection: first requester found scanning upward from the one after the last winner.
  always_comb begin
    win_s    = '0;
    found_s  = 1'b0;
    rr_idx_s = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx_s = (int'(last_r) + k) % NUM_REQ;
      if (req[rr_idx_s] && !found_s) begin
        win_s   = IDX_W'(rr_idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  // Access sequencer: arbitration, memory strobes, read-latency tracking and response routing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      last_r    <= IDX_W'(NUM_REQ - 1);
      win_r     <= '0;
      cnt_r     <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // pulses and the memory command return to zero unless set below
      gnt       <= '0;
      rvalid    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
            mem_en    <= 1'b1;
            mem_we    <= we[win_s];
            mem_addr  <= addr[int'(win_s)*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[int'(win_s)*DATA_W +: DATA_W];
            win_r     <= win_s;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_r    <= win_s;
`endif
            state_r   <= ACCESS;
            busy      <= 1'b1;
          end else begin
            state_r   <= IDLE;
            busy      <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_we) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= RESP;
            busy    <= 1'b1;
            cnt_r   <= CNT_W'(MEM_LAT);
          end
        end
        RESP: begin
          if (cnt_r == CNT_W'(1)) begin
            rdata   <= mem_rdata;
            rvalid  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_r;
            cnt_r   <= '0;
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
            state_r <= RESP;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a 2-requester/latency-1 instance and a
// 4-requester/latency-3 instance, each with a small memory model and its own monitor.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] sel;
    logic       we;
    logic [7:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t s_gq[$], s_rq[$], b_gq[$], b_rq[$];

  function automatic logic [15:0] rom(input logic [7:0] a);
    case (a)
      8'h12:   rom = 16'hABCD;
      8'h30:   rom = 16'h1111;
      8'h40:   rom = 16'h2222;
      8'h20:   rom = 16'h0BEE;
      8'h55:   rom = 16'h1234;
      default: rom = {a, a};
    endcase
  endfunction

  // ---------------- small instance: NUM_REQ=2, MEM_LAT=1 ----------------
  logic        s_rst_n;
  logic [1:0]  s_req, s_we, s_gnt, s_rvalid;
  logic [15:0] s_addr;
  logic [31:0] s_wdata;
  logic [15:0] s_rdata, s_mem_wdata, s_mem_rdata;
  logic        s_busy, s_mem_en, s_mem_we;
  logic [7:0]  s_mem_addr;

  dmem_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) u_small (
    .clk(clk), .reset_n(s_rst_n), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata),
    .gnt(s_gnt), .rvalid(s_rvalid), .rdata(s_rdata), .busy(s_busy), .mem_en(s_mem_en),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata));

  int          s_cnt = 0;
  logic [7:0]  s_ma = 8'h00, s_wa = 8'h00;
  logic [15:0] s_wd = 16'h0000;
  logic        s_wv = 1'b0;

  // memory model: data valid only exactly one cycle after mem_en, garbage otherwise
  always @(posedge clk) begin
    if (s_mem_en && s_mem_we) begin
      s_wv <= 1'b1; s_wa <= s_mem_addr; s_wd <= s_mem_wdata;
    end
    if (s_mem_en) begin
      s_cnt <= 1; s_ma <= s_mem_addr;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
    end
  end
  assign s_mem_rdata = (s_cnt == 1) ? ((s_wv && s_wa == s_ma) ? s_wd : rom(s_ma)) : 16'hDEAD;

  always @(negedge clk) begin : mon_s
    ev_t e;
    if (s_rst_n) begin
      if (s_gnt != 2'b00) begin
        if (s_gq.size() == 0) chk("s_unexpected_gnt", 32'(s_gnt), 32'h0);
        else begin
          e = s_gq.pop_front();
          chk("s_gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("s_gnt", 32'(s_gnt), 32'(e.sel));
          chk("s_mem_en", 32'(s_mem_en), 32'h1);
          chk("s_mem_we", 32'(s_mem_we), 32'(e.we));
          chk("s_mem_addr", 32'(s_mem_addr), 32'(e.addr));
          chk("s_mem_wdata", 32'(s_mem_wdata), 32'(e.data));
          chk("s_busy_at_gnt", 32'(s_busy), 32'h1);
        end
      end else begin
        chk("s_idle_port", {7'h0, s_mem_en, s_mem_we, s_mem_addr, s_mem_wdata}, 32'h0);
      end
      if (s_rvalid != 2'b00) begin
        if (s_rq.size() == 0) chk("s_unexpected_rvalid", 32'(s_rvalid), 32'h0);
        else begin
          e = s_rq.pop_front();
          chk("s_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("s_rvalid", 32'(s_rvalid), 32'(e.sel));
          chk("s_rdata", 32'(s_rdata), 32'(e.data));
          chk("s_busy_at_rvalid", 32'(s_busy), 32'h0);
        end
      end
    end
  end

  // ---------------- big instance: NUM_REQ=4, MEM_LAT=3 ----------------
  logic        b_rst_n;
  logic [3:0]  b_req, b_we, b_gnt, b_rvalid;
  logic [31:0] b_addr;
  logic [63:0] b_wdata;
  logic [15:0] b_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_busy, b_mem_en, b_mem_we;
  logic [7:0]  b_mem_addr;

  dmem_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) u_big (
    .clk(clk), .reset_n(b_rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .busy(b_busy), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  int         b_cnt = 0;
  logic [7:0] b_ma = 8'h00;

  // memory model: data valid only exactly three cycles after mem_en
  always @(posedge clk) begin
    if (b_mem_en) begin
      b_cnt <= 3; b_ma <= b_mem_addr;
    end else if (b_cnt != 0) begin
      b_cnt <= b_cnt - 1;
    end
  end
  assign b_mem_rdata = (b_cnt == 1) ? rom(b_ma) : 16'hDEAD;

  always @(negedge clk) begin : mon_b
    ev_t e;
    if (b_rst_n) begin
      if (b_gnt != 4'b0000) begin
        if (b_gq.size() == 0) chk("b_unexpected_gnt", 32'(b_gnt), 32'h0);
        else begin
          e = b_gq.pop_front();
          chk("b_gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("b_gnt", 32'(b_gnt), 32'(e.sel));
          chk("b_mem_en", 32'(b_mem_en), 32'h1);
          chk("b_mem_addr", 32'(b_mem_addr), 32'(e.addr));
        end
      end
      if (b_rvalid != 4'b0000) begin
        if (b_rq.size() == 0) chk("b_unexpected_rvalid", 32'(b_rvalid), 32'h0);
        else begin
          e = b_rq.pop_front();
          chk("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("b_rvalid", 32'(b_rvalid), 32'(e.sel));
          chk("b_rdata", 32'(b_rdata), 32'(e.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic s_idle(input string tag);
    chk({tag, "_gnt"}, 32'(s_gnt), 32'h0);
    chk({tag, "_rvalid"}, 32'(s_rvalid), 32'h0);
    chk({tag, "_rdata"}, 32'(s_rdata), 32'h0);
    chk({tag, "_port"}, {6'h0, s_busy, s_mem_en, s_mem_we, s_mem_addr, s_mem_wdata}, 32'h0);
  endtask

  int  n, m;
  logic [7:0] w;

  initial begin
    s_rst_n = 1'b0; b_rst_n = 1'b0;
    s_req = 2'b00; s_we = 2'b00; s_addr = 16'h0; s_wdata = 32'h0;
    b_req = 4'b0000; b_we = 4'b0000; b_addr = 32'h0; b_wdata = 64'h0;
    tick(2);
    s_idle("reset");
    chk("b_reset_port", {11'h0, b_gnt, b_rvalid, b_busy, b_mem_en, b_mem_addr, 2'b00}, 32'h0);
    s_rst_n = 1'b1; b_rst_n = 1'b1;
    tick(1);

    // single read from core
    n = cyc;
    s_req = 2'b01; s_we = 2'b00; s_addr = {8'h00, 8'h12}; s_wdata = 32'h0;
    s_gq.push_back('{n + 1, 8'h01, 1'b0, 8'h12, 16'h0});
    s_rq.push_back('{n + 3, 8'h01, 1'b0, 8'h00, 16'hABCD});
    tick(1); s_req = 2'b00;
    tick(3);

    // back-to-back writes from requester 1
    n = cyc;
    s_req = 2'b10; s_we = 2'b10; s_addr = {8'h7F, 8'h00}; s_wdata = {16'h5A5A, 16'h0};
    s_gq.push_back('{n + 1, 8'h02, 1'b1, 8'h7F, 16'h5A5A});
    s_gq.push_back('{n + 3, 8'h02, 1'b1, 8'h7F, 16'h5A5A});
    tick(3); s_req = 2'b00; s_we = 2'b00;
    tick(2);

    // read back the written word
    n = cyc;
    s_req = 2'b10; s_wdata = 32'h0;
    s_gq.push_back('{n + 1, 8'h02, 1'b0, 8'h7F, 16'h0});
    s_rq.push_back('{n + 3, 8'h02, 1'b0, 8'h00, 16'h5A5A});
    tick(1); s_req = 2'b00;
    tick(3);

    // reset in the middle of a read, then both requesters held
    n = cyc;
    s_req = 2'b01; s_addr = {8'h40, 8'h30};
    s_gq.push_back('{n + 1, 8'h01, 1'b0, 8'h30, 16'h0});
    tick(1); s_req = 2'b00;
    tick(1); s_rst_n = 1'b0;
    tick(1);
    s_idle("midread_reset");
    s_req = 2'b11;
    tick(1); s_rst_n = 1'b1;
    m = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      w = 8'h01;
`else
      w = (k % 2 == 0) ? 8'h01 : 8'h02;
`endif
      s_gq.push_back('{m + 1 + 3*k, w, 1'b0, (w == 8'h01) ? 8'h30 : 8'h40, 16'h0});
      s_rq.push_back('{m + 3 + 3*k, w, 1'b0, 8'h00, (w == 8'h01) ? 16'h1111 : 16'h2222});
    end
    tick(10); s_req = 2'b00;
    tick(3);

    // long-latency instance: read from requester 3, then pointer wrap
    n = cyc;
    b_req = 4'b1000; b_addr = {8'h55, 8'h00, 8'h00, 8'h20};
    b_gq.push_back('{n + 1, 8'h08, 1'b0, 8'h55, 16'h0});
    b_rq.push_back('{n + 5, 8'h08, 1'b0, 8'h00, 16'h1234});
    tick(1); b_req = 4'b0000;
    tick(1);
    chk("b_busy_in_resp", 32'(b_busy), 32'h1);
    tick(3);
    m = cyc;
    b_req = 4'b1001;
    b_gq.push_back('{m + 1, 8'h01, 1'b0, 8'h20, 16'h0});
    b_rq.push_back('{m + 5, 8'h01, 1'b0, 8'h00, 16'h0BEE});
`ifdef DMEM_ARB_FIXED_PRIO_EN
    b_gq.push_back('{m + 6, 8'h01, 1'b0, 8'h20, 16'h0});
    b_rq.push_back('{m + 10, 8'h01, 1'b0, 8'h00, 16'h0BEE});
`else
    b_gq.push_back('{m + 6, 8'h08, 1'b0, 8'h55, 16'h0});
    b_rq.push_back('{m + 10, 8'h08, 1'b0, 8'h00, 16'h1234});
`endif
    tick(6); b_req = 4'b0000;
    tick(6);

    chk("s_gnt_queue_drained", 32'(s_gq.size()), 32'h0);
    chk("s_rvalid_queue_drained", 32'(s_rq.size()), 32'h0);
    chk("b_gnt_queue_drained", 32'(b_gq.size()), 32'h0);
    chk("b_rvalid_queue_drained", 32'(b_rq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
